// File: rtl/target_number_gen_pkg.sv
// Shared types and constants for the target number generator.
// FIXED_TARGETS holds the BCD targets used when TARGET_FIXED_TABLE_EN is defined.
package target_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Fibonacci feedback masks; bit i set means register bit i feeds the XOR.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      9:       return 32'h0000_0110;
      10:      return 32'h0000_0240;
      11:      return 32'h0000_0500;
      12:      return 32'h0000_0E08;
      13:      return 32'h0000_1C80;
      14:      return 32'h0000_3802;
      15:      return 32'h0000_6000;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_B400;
    endcase
  endfunction

  // Indexed [max_digit][round]; row/column 0 unused.
  localparam logic [31:0] FIXED_TARGETS [4][4] = '{
    '{32'h0, 32'h0,   32'h0,   32'h0  },
    '{32'h0, 32'h2,   32'h8,   32'h3  },
    '{32'h0, 32'h57,  32'h96,  32'h21 },
    '{32'h0, 32'h123, 32'h000, 32'h999}
  };

endpackage

// File: rtl/target_number_gen_if.sv
// Request/target bus between game control and the target number generator.
interface target_number_gen_if #(
  parameter int NUM_DIGITS = 3,
  parameter int MAX_ROUND  = 3
);
  localparam int DW = $clog2(NUM_DIGITS + 1);
  localparam int RW = $clog2(MAX_ROUND + 1);

  logic                    new_target;
  logic [DW-1:0]           max_digit;
  logic                    busy;
  logic                    target_valid;
  logic [4*NUM_DIGITS-1:0] target_digits;
  logic [RW-1:0]           round;
  logic                    level_done;

  modport master (
    output new_target, max_digit,
    input  busy, target_valid, target_digits, round, level_done
  );

  modport slave (
    input  new_target, max_digit,
    output busy, target_valid, target_digits, round, level_done
  );
endinterface

// File: rtl/target_number_gen_lfsr_core.sv
// Free-running Fibonacci LFSR; shifts left with the feedback bit entering at bit 0.
module lfsr_core
  import target_gen_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [LFSR_W-1:0] q
);
  localparam logic [31:0]       TAPS_ALL = lfsr_taps(LFSR_W);
  localparam logic [LFSR_W-1:0] TAPS     = TAPS_ALL[LFSR_W-1:0];

  logic [LFSR_W-1:0] q_q, q_d;

  always_comb begin
    q_d = {q_q[LFSR_W-2:0], ^(q_q & TAPS)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= SEED;
    else          q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/target_number_gen.sv
// Serial BCD target generator with round tracking; TARGET_FIXED_TABLE_EN selects the fixed demo table.
// state | meaning: IDLE wait for request | GEN write one digit per accepted nibble | DONE publish, bump round
module target_number_gen
  import target_gen_pkg::*;
#(
  parameter int                NUM_DIGITS = 3,
  parameter int                MAX_ROUND  = 3,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(16'hACE1),
  parameter int                MAX_REJECT = 8
) (
  input logic                clk,
  input logic                reset_n,
  target_number_gen_if.slave tif
);
  localparam int DW = $clog2(NUM_DIGITS + 1);
  localparam int RW = $clog2(MAX_ROUND + 1);
  localparam int JW = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;

  state_t                  state_q, state_d;
  logic [DW-1:0]           idx_q, idx_d;
  logic [DW-1:0]           maxd_q, maxd_d;
  logic [JW-1:0]           rej_q, rej_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic [RW-1:0]           round_q, round_d;
  logic                    lvl_q, lvl_d;

  logic [LFSR_W-1:0] lfsr_q;
  logic [3:0]        nib;
  logic              wr;
  logic [3:0]        val;
  logic              unused_lfsr;

  lfsr_core #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (lfsr_q)
  );

  assign nib = lfsr_q[3:0];

`ifdef TARGET_FIXED_TABLE_EN
  int          fx_m, fx_r;
  logic [31:0] fx_ent;
  assign unused_lfsr = ^lfsr_q;
`else
  assign unused_lfsr = ^lfsr_q[LFSR_W-1:4];
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    maxd_d   = maxd_q;
    rej_d    = rej_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    round_d  = round_q;
    lvl_d    = 1'b0;
    wr       = 1'b0;
    val      = 4'd0;
`ifdef TARGET_FIXED_TABLE_EN
    fx_m   = 0;
    fx_r   = 0;
    fx_ent = 32'h0;
`endif
    case (state_q)
      IDLE: begin
        if (tif.new_target) begin
          if (tif.max_digit == '0)                   maxd_d = DW'(1);
          else if (32'(tif.max_digit) > NUM_DIGITS)  maxd_d = DW'(NUM_DIGITS);
          else                                       maxd_d = tif.max_digit;
          idx_d   = '0;
          rej_d   = '0;
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = GEN;
        end
      end
      GEN: begin
`ifdef TARGET_FIXED_TABLE_EN
        fx_m   = (32'(maxd_q) <= 3) ? 32'(maxd_q) : 0;
        fx_r   = (32'(round_q) <= 3) ? 32'(round_q) : 0;
        fx_ent = FIXED_TARGETS[fx_m][fx_r];
        wr     = 1'b1;
        val    = fx_ent[32'(idx_q)*4 +: 4];
`else
        if (idx_q >= maxd_q) begin
          wr = 1'b1;
        end else if (nib <= BCD_MAX) begin
          wr  = 1'b1;
          val = nib;
        end else if (rej_q != JW'(MAX_REJECT - 1)) begin
          rej_d = rej_q + JW'(1);
        end else begin
          // Out of retries: fold 10..15 down to 0..5 so latency stays bounded.
          wr  = 1'b1;
          val = nib - 4'd10;
        end
`endif
        if (wr) begin
          digits_d[32'(idx_q)*4 +: 4] = val;
          rej_d = '0;
          if (idx_q == DW'(NUM_DIGITS - 1)) state_d = DONE;
          else                              idx_d   = idx_q + DW'(1);
        end
      end
      DONE: begin
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (round_q == RW'(MAX_ROUND)) begin
          round_d = RW'(1);
          lvl_d   = 1'b1;
        end else begin
          round_d = round_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      maxd_q   <= DW'(1);
      rej_q    <= '0;
      digits_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      round_q  <= RW'(1);
      lvl_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      maxd_q   <= maxd_d;
      rej_q    <= rej_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      round_q  <= round_d;
      lvl_q    <= lvl_d;
    end
  end

  assign tif.busy          = busy_q;
  assign tif.target_valid  = valid_q;
  assign tif.target_digits = digits_q;
  assign tif.round         = round_q;
  assign tif.level_done    = lvl_q;
endmodule

// File: tb/tb_target_number_gen.sv
// Directed and randomized checks of target_number_gen against a nibble-stream reference model.
module tb_target_number_gen;
  import target_gen_pkg::*;

  localparam int          ND      = 3;
  localparam int          MR      = 3;
  localparam int          LW      = 16;
  localparam int          MRJ     = 8;
  // Seed chosen so the first eight GEN nibbles after reset are all above 9.
  localparam logic [15:0] SEED_TB = 16'h8347;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  target_number_gen_if #(.NUM_DIGITS(ND), .MAX_ROUND(MR)) tif ();

  target_number_gen #(
    .NUM_DIGITS (ND),
    .MAX_ROUND  (MR),
    .LFSR_W     (LW),
    .SEED       (SEED_TB),
    .MAX_REJECT (MRJ)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tif     (tif)
  );

  int total = 0;
  int bad = 0;
  int exp_round = 1;
  logic [15:0] m_lfsr;

  // x^16 + x^14 + x^13 + x^11 + 1
  function automatic logic [15:0] step16(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= SEED_TB;
    else          m_lfsr <= step16(m_lfsr);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // s is the LFSR value seen in the first GEN cycle; returns digits and GEN cycle count.
  function automatic void predict(input logic [15:0] s, input int md, input int rnd,
                                  output logic [4*ND-1:0] dig, output int cyc);
    int m;
    int idx;
    int rej;
    int v;
    int p;
    logic [3:0] nib;
    int tbl [1:3][1:3];
    m = (md == 0) ? 1 : ((md > ND) ? ND : md);
    idx = 0;
    rej = 0;
    dig = '0;
    cyc = 0;
    tbl = '{'{2, 8, 3}, '{57, 96, 21}, '{123, 0, 999}};
    v = 0;
    p = 1;
    nib = 4'd0;
`ifdef TARGET_FIXED_TABLE_EN
    if (m <= 3 && rnd >= 1 && rnd <= 3) v = tbl[m][rnd];
    for (int i = 0; i < ND; i++) begin
      dig[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    cyc = ND;
`else
    while (idx < ND) begin
      nib = s[3:0];
      s = step16(s);
      cyc++;
      if (idx >= m) begin
        dig[idx*4 +: 4] = 4'd0;
        idx++;
        rej = 0;
      end else if (nib <= 4'd9) begin
        dig[idx*4 +: 4] = nib;
        idx++;
        rej = 0;
      end else if (rej < MRJ - 1) begin
        rej++;
      end else begin
        dig[idx*4 +: 4] = nib - 4'd10;
        idx++;
        rej = 0;
      end
    end
`endif
  endfunction

  // Call immediately (#1) after the accepting edge.
  task automatic wait_done(input int md, input string tag);
    logic [4*ND-1:0] ed;
    int ec;
    int got;
    bit lvl;
    predict(m_lfsr, md, exp_round, ed, ec);
    got = 0;
    for (int k = 1; k <= ND * MRJ + 8; k++) begin
      @(posedge clk); #1;
      if (tif.target_valid) begin
        got = k;
        break;
      end
      chk({tag, "_busy"}, tif.busy, 1'b1);
    end
    lvl = (exp_round == MR);
    exp_round = lvl ? 1 : exp_round + 1;
    chk({tag, "_latency"}, got, ec + 1);
    chk({tag, "_digits"}, tif.target_digits, ed);
    chk({tag, "_busy_end"}, tif.busy, 1'b0);
    chk({tag, "_round"}, tif.round, exp_round);
    chk({tag, "_level_done"}, tif.level_done, lvl);
    @(posedge clk); #1;
    chk({tag, "_level_done_drop"}, tif.level_done, 1'b0);
    chk({tag, "_valid_hold"}, tif.target_valid, 1'b1);
    chk({tag, "_digits_hold"}, tif.target_digits, ed);
  endtask

  task automatic request(input int md, input string tag);
    @(negedge clk);
    tif.new_target = 1'b1;
    tif.max_digit  = 2'(md);
    @(posedge clk); #1;
    tif.new_target = 1'b0;
    chk({tag, "_accept"}, tif.busy, 1'b1);
    wait_done(md, tag);
  endtask

  initial begin
    logic [4*ND-1:0] ed;
    int ec;
    int got;
    int r0;
    tif.new_target = 1'b0;
    tif.max_digit  = 2'd0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", tif.busy, 1'b0);
    chk("rst_valid", tif.target_valid, 1'b0);
    chk("rst_digits", tif.target_digits, 0);
    chk("rst_round", tif.round, 1);
    chk("rst_level_done", tif.level_done, 1'b0);
    chk("rst_lfsr", dut.u_lfsr.q, SEED_TB);

    // Request pending at reset release: first GEN nibbles exercise the fold path
    tif.new_target = 1'b1;
    tif.max_digit  = 2'd3;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    tif.new_target = 1'b0;
    chk("lfsr_first", dut.u_lfsr.q, step16(SEED_TB));
    chk("fold_accept", tif.busy, 1'b1);
    wait_done(3, "fold");

    // One active digit: upper digits forced to zero
    request(1, "md1");
    chk("md1_upper_zero", tif.target_digits[4*ND-1:4], 0);
    chk("md1_bcd", tif.target_digits[3:0] <= 4'd9, 1'b1);

    // max_digit 0 clamps to 1
    request(0, "md0");

    // Randomized request timing and digit counts
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 6)) @(posedge clk);
      request(int'($urandom_range(0, 3)), "rand");
    end

    // Requests during GEN and on the DONE cycle are dropped
    r0 = exp_round;
    @(negedge clk);
    tif.new_target = 1'b1;
    tif.max_digit  = 2'd3;
    @(posedge clk); #1;
    tif.new_target = 1'b0;
    predict(m_lfsr, 3, exp_round, ed, ec);
    got = 0;
    for (int k = 1; k <= ND * MRJ + 8; k++) begin
      @(negedge clk);
      tif.new_target = (k == 2) || (k == ec + 1);
      @(posedge clk); #1;
      if (tif.target_valid) begin
        got = k;
        break;
      end
      chk("ign_busy", tif.busy, 1'b1);
    end
    @(negedge clk);
    tif.new_target = 1'b0;
    exp_round = (r0 == MR) ? 1 : r0 + 1;
    chk("ign_latency", got, ec + 1);
    chk("ign_digits", tif.target_digits, ed);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_no_restart", tif.busy, 1'b0);
    chk("ign_valid", tif.target_valid, 1'b1);
    chk("ign_round", tif.round, exp_round);

    // Asynchronous reset mid-GEN
    @(negedge clk);
    tif.new_target = 1'b1;
    tif.max_digit  = 2'd3;
    @(posedge clk); #1;
    tif.new_target = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", tif.busy, 1'b0);
    chk("mid_rst_valid", tif.target_valid, 1'b0);
    chk("mid_rst_digits", tif.target_digits, 0);
    chk("mid_rst_round", tif.round, 1);
    chk("mid_rst_lfsr", dut.u_lfsr.q, SEED_TB);
    exp_round = 1;
    @(negedge clk);
    reset_n = 1'b1;
    request(3, "post_rst");
    request(2, "post_rst2");

    #1;
    chk("lfsr_track", dut.u_lfsr.q, m_lfsr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
